hilo_muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with architectural HI/LO registers, on the execute side.

---
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/hilo_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Command/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       aluop;
  logic             is_unsigned;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, aluop, is_unsigned, rs, rt,
    input  busy, stall, result, result_valid, hi, lo
  );

  modport slave (
    input  start, aluop, is_unsigned, rs, rt,
    output busy, stall, result, result_valid, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a single sign-fix/commit cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clock,
  input logic          reset,
  hilo_muldiv_if.slave bus
);

  localparam logic [5:0] MULT_OP       = 6'b000010;
  localparam logic [5:0] DIV_OP        = 6'b000011;
  localparam logic [5:0] MFHI_OP       = 6'b000100;
  localparam logic [5:0] MFLO_OP       = 6'b000101;
  localparam logic [5:0] MUL_PSEUDO_OP = 6'b100010;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [1:0] {K_MULT, K_DIV, K_MUL} kind_t;

  state_t           state_q, next_state;
  kind_t            kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q, result_q;
  logic             result_valid_q;

  // Iteration datapath: acc is the running high product / partial remainder,
  // mq the multiplier / quotient shift register, opnd the multiplicand / divisor.
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
  logic             a_neg_q, b_neg_q, div_zero_q;

  // Command decode
  logic is_mult, is_div, is_mul, is_mfhi, is_mflo, recognised, accept, launch;
  assign is_mult    = (bus.aluop == MULT_OP);
  assign is_div     = (bus.aluop == DIV_OP);
  assign is_mul     = (bus.aluop == MUL_PSEUDO_OP);
  assign is_mfhi    = (bus.aluop == MFHI_OP);
  assign is_mflo    = (bus.aluop == MFLO_OP);
  assign recognised = is_mult | is_div | is_mul | is_mfhi | is_mflo;
  assign accept     = bus.start & ~busy_q & recognised;
  assign launch     = accept & (is_mult | is_div | is_mul);

  // Operand conditioning: MUL is always signed, otherwise insn[0] selects.
  logic             signed_op, a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  assign signed_op = is_mul | ~bus.is_unsigned;
  assign a_neg_in  = signed_op & bus.rs[WIDTH-1];
  assign b_neg_in  = signed_op & bus.rt[WIDTH-1];
  assign a_mag_in  = a_neg_in ? -bus.rs : bus.rs;
  assign b_mag_in  = b_neg_in ? -bus.rt : bus.rt;

  // One multiply step: conditional add, then shift {acc,mq} right by one.
  logic [WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring divide step: shift in next dividend bit, subtract if it fits.
  // The trial remainder is always below 2*divisor, so the W-bit difference is exact.
  logic [WIDTH:0]   sub_shift;
  logic             sub_ge;
  logic [WIDTH-1:0] sub_rem;
  assign sub_shift = {acc_q, mq_q[WIDTH-1]};
  assign sub_ge    = (sub_shift >= {1'b0, opnd_q});
  assign sub_rem   = sub_shift[WIDTH-1:0] - opnd_q;

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_mag = {acc_q, mq_q};
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? -mq_q : mq_q;
  assign rem_fix  = a_neg_q ? -acc_q : acc_q;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:    if (launch) next_state = RUN;
      RUN:     if (cnt_q == CNT_W'(WIDTH-1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q         <= 1'b0;
      cnt_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      busy_q         <= (next_state != IDLE);
      result_valid_q <= 1'b0;

      if (launch)              cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + CNT_W'(1);

      if (accept && is_mfhi) begin
        result_q       <= hi_q;
        result_valid_q <= 1'b1;
      end
      if (accept && is_mflo) begin
        result_q       <= lo_q;
        result_valid_q <= 1'b1;
      end

      if (state_q == FIX) begin
        unique case (kind_q)
          K_MULT: begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          K_DIV: begin
            hi_q <= rem_fix;
            lo_q <= div_zero_q ? '1 : quo_fix;
          end
          default: begin
            result_q       <= prod_fix[WIDTH-1:0];
            result_valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // NOTE: the iteration datapath has no reset; it is fully loaded on launch before it is ever read.
  always_ff @(posedge clock) begin
    if (launch) begin
      a_neg_q    <= a_neg_in;
      b_neg_q    <= b_neg_in;
      div_zero_q <= (bus.rt == '0);
      acc_q      <= '0;
      if (is_div) begin
        kind_q <= K_DIV;
        mq_q   <= a_mag_in;
        opnd_q <= b_mag_in;
      end else begin
        kind_q <= is_mul ? K_MUL : K_MULT;
        mq_q   <= b_mag_in;
        opnd_q <= a_mag_in;
      end
    end else if (state_q == RUN) begin
      if (kind_q == K_DIV) begin
        acc_q <= sub_ge ? sub_rem : sub_shift[WIDTH-1:0];
        mq_q  <= {mq_q[WIDTH-2:0], sub_ge};
      end else begin
        acc_q <= add_sum[WIDTH:1];
        mq_q  <= {add_sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.stall        = bus.start & busy_q & recognised;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus randomized
// commands compared against an arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] ADD_OP   = 6'b000000;
  localparam logic [5:0] MULT_OP  = 6'b000010;
  localparam logic [5:0] DIV_OP   = 6'b000011;
  localparam logic [5:0] MFHI_OP  = 6'b000100;
  localparam logic [5:0] MFLO_OP  = 6'b000101;
  localparam logic [5:0] MUL_OP   = 6'b100010;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hilo_muldiv_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint sa, sb, p;
    if (!sgn) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return p;
  endfunction

  // Returns {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue MULT/DIV/MUL and follow it to completion.
  task automatic do_long(input logic [5:0] op, input bit uns, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    int cyc, pulses;
    @(negedge clock);
    bus.start = 1'b1; bus.aluop = op; bus.is_unsigned = uns; bus.rs = a; bus.rt = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 0; pulses = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      if (bus.result_valid) pulses++;
      @(posedge clock); #1;
      cyc++;
    end
    check("busy_len", cyc, W + 1);
    check("valid_while_busy", pulses, 0);
    if (op == MULT_OP) begin
      p = ref_mul(a, b, !uns);
      m_hi = p[63:32]; m_lo = p[31:0];
      check("mult_no_valid", bus.result_valid, 1'b0);
    end else if (op == DIV_OP) begin
      p = ref_div(a, b, !uns);
      m_hi = p[63:32]; m_lo = p[31:0];
      check("div_no_valid", bus.result_valid, 1'b0);
    end else begin
      p = ref_mul(a, b, 1'b1);
      check("mul_result", bus.result, p[31:0]);
      check("mul_valid", bus.result_valid, 1'b1);
    end
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    if (op == MUL_OP) begin
      @(posedge clock); #1;
      check("mul_pulse_width", bus.result_valid, 1'b0);
    end
  endtask

  task automatic do_mf(input logic [5:0] op);
    @(negedge clock);
    bus.start = 1'b1; bus.aluop = op; bus.is_unsigned = $urandom_range(0, 1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("mf_result", bus.result, (op == MFHI_OP) ? m_hi : m_lo);
    check("mf_valid", bus.result_valid, 1'b1);
    check("mf_no_busy", bus.busy, 1'b0);
    @(posedge clock); #1;
    check("mf_pulse_width", bus.result_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, n_nostall, n_bad;
    logic [5:0] op;

    bus.start = 1'b0; bus.aluop = '0; bus.is_unsigned = 1'b0; bus.rs = '0; bus.rt = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_valid", bus.result_valid, 1'b0);
    check("rst_result", bus.result, '0);
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    @(negedge clock);
    reset = 1'b0;

    // Directed examples with literal expectations
    do_long(MULT_OP, 1'b0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg3x7_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg3x7_lo", bus.lo, 32'hFFFF_FFEB);
    do_long(MULT_OP, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    do_long(MULT_OP, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_m1m1_hi", bus.hi, 32'h0);
    check("mult_m1m1_lo", bus.lo, 32'h1);
    do_long(DIV_OP, 1'b0, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg7_hi", bus.hi, 32'hFFFF_FFFF);
    do_long(DIV_OP, 1'b1, 32'd7, 32'd0);
    check("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", bus.hi, 32'd7);
    do_long(DIV_OP, 1'b0, 32'hFFFF_FFF9, 32'd0);
    check("div_zero_signed_lo", bus.lo, 32'hFFFF_FFFF);
    check("div_zero_signed_hi", bus.hi, 32'hFFFF_FFF9);
    do_long(DIV_OP, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);

    // MFLO held behind a DIVU: stalls for the whole operation, then accepted
    @(negedge clock);
    bus.start = 1'b1; bus.aluop = DIV_OP; bus.is_unsigned = 1'b1; bus.rs = 32'd100; bus.rt = 32'd7;
    @(posedge clock); #1;
    bus.aluop = MFLO_OP;
    m_lo = 32'd14; m_hi = 32'd2;
    cyc = 0; n_nostall = 0;
    while (cyc < 100) begin
      @(negedge clock);
      if (!bus.busy) break;
      if (!bus.stall) n_nostall++;
      cyc++;
    end
    check("stall_busy_len", cyc, W + 1);
    check("stall_missing", n_nostall, 0);
    check("stall_after_busy", bus.stall, 1'b0);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("held_mflo_result", bus.result, 32'd14);
    check("held_mflo_valid", bus.result_valid, 1'b1);
    check("held_mflo_no_busy", bus.busy, 1'b0);
    check("divu_100_7_hi", bus.hi, 32'd2);

    // Reset on the 10th RUN cycle of a DIV aborts it
    @(negedge clock);
    bus.start = 1'b1; bus.aluop = DIV_OP; bus.is_unsigned = 1'b0; bus.rs = 32'd12345; bus.rt = 32'd17;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);
    n_bad = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.result_valid || bus.busy || bus.hi != 0 || bus.lo != 0) n_bad++;
    end
    check("abort_quiet", n_bad, 0);

    // MUL leaves HI/LO alone
    do_long(DIV_OP, 1'b1, 32'h0000_2211, 32'h0000_0100);
    check("preset_hi", bus.hi, 32'h11);
    check("preset_lo", bus.lo, 32'h22);
    do_long(MUL_OP, 1'b1, 32'h0001_0000, 32'h0001_0003);
    check("mul_literal", bus.result, 32'h0003_0000);
    check("mul_keeps_hi", bus.hi, 32'h11);
    check("mul_keeps_lo", bus.lo, 32'h22);

    // Unrecognised opcode is ignored
    @(negedge clock);
    bus.start = 1'b1; bus.aluop = ADD_OP; bus.rs = $urandom; bus.rt = $urandom;
    n_bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.stall || bus.busy || bus.result_valid) n_bad++;
    end
    bus.start = 1'b0;
    check("add_ignored", n_bad, 0);
    check("add_hi", bus.hi, m_hi);
    check("add_lo", bus.lo, m_lo);

    // Randomized command stream against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       op = MULT_OP;
        1:       op = DIV_OP;
        2:       op = MUL_OP;
        3:       op = MFHI_OP;
        default: op = MFLO_OP;
      endcase
      if (op == MFHI_OP || op == MFLO_OP) do_mf(op);
      else do_long(op, bit'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
